// File: rtl/mmu_input_packer.sv
// mmu_input_packer: packs 64-bit operand beats into 256-bit rows and frames
// them for the matrix multiplication unit (start pulse, settle gap,
// weight rows, one separator cycle, data rows).
//
// Handshake: an input beat transfers on a rising clock edge where
// in_tvalid && in_tready are both high. in_tready depends only on registered
// state. The MMU side has no ready: every cycle with m_valid=1 delivers one row.
module mmu_input_packer #(
    parameter int IN_W       = 64,
    parameter int LANE_W     = 16,
    parameter int LANES      = 16,
    parameter int ROWS       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int START_GAP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [IN_W-1:0]         in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    output logic                    ap_start,
    output logic                    m_valid,
    output logic [LANES*LANE_W-1:0] m_data,
    output logic                    busy,
    output logic                    err_len
);

    localparam int ROW_W     = LANES * LANE_W;
    localparam int BEATS     = ROW_W / IN_W;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int JOB_BEATS = 2 * ROWS * BEATS;
    localparam int JBW       = $clog2(JOB_BEATS);
    localparam int RCW       = $clog2(2 * ROWS + 1);
    localparam int PCW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GCW       = $clog2(START_GAP) + 1;

    localparam logic [BW-1:0]  LAST_BEAT   = BW'(BEATS - 1);
    localparam logic [JBW-1:0] W_LAST_BEAT = JBW'(ROWS * BEATS - 1);
    localparam logic [JBW-1:0] D_LAST_BEAT = JBW'(JOB_BEATS - 1);
    localparam logic [RCW-1:0] TOTAL_ROWS  = RCW'(2 * ROWS);
    localparam logic [PCW-1:0] LAST_ROW    = PCW'(ROWS - 1);
    localparam logic [GCW-1:0] GAP_LAST    = GCW'(START_GAP - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        GAP    = 3'd2,
        W_ROWS = 3'd3,
        SEP    = 3'd4,
        D_ROWS = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;

    logic [ROW_W-1:0] pack_q;
    logic [ROW_W-1:0] row_in;
    logic [BW-1:0]    beat_idx;
    logic [JBW-1:0]   beat_cnt;
    logic [RCW-1:0]   rows_packed;
    logic [PCW-1:0]   pop_cnt;
    logic [GCW-1:0]   gap_cnt;

    logic accept;
    logic push;
    logic pop;
    logic job_go;
    logic tlast_exp;
    logic ap_start_d;
    logic busy_d;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign in_tready = ((state == GAP) || (state == W_ROWS) ||
                        (state == SEP) || (state == D_ROWS)) &&
                       !fifo_full && (rows_packed != TOTAL_ROWS);

    assign accept    = in_tvalid && in_tready;
    assign push      = accept && (beat_idx == LAST_BEAT);
    assign pop       = ((state == W_ROWS) || (state == D_ROWS)) && !fifo_empty;
    assign job_go    = (state == IDLE) && cfg_start;
    assign tlast_exp = (beat_cnt == W_LAST_BEAT) || (beat_cnt == D_LAST_BEAT);

    // Current beat merged into the pack register; on the last beat this is the row pushed.
    always_comb begin
        row_in = pack_q;
        row_in[beat_idx*IN_W +: IN_W] = in_tdata;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: framing sequence of one job.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = START;
            START:   state_next = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_next = W_ROWS;
            W_ROWS:  if (pop && (pop_cnt == LAST_ROW)) state_next = SEP;
            SEP:     state_next = D_ROWS;
            D_ROWS:  if (pop && (pop_cnt == LAST_ROW)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: values loaded into the output registers next edge.
    always_comb begin
        ap_start_d = (state_next == START);
        busy_d     = (state_next != IDLE);
    end

    // Registered MMU-side outputs; m_data holds while no row is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_start <= 1'b0;
            busy     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            ap_start <= ap_start_d;
            busy     <= busy_d;
            m_valid  <= pop;
            if (pop) begin
                m_data <= mem[rd_ptr[PW-1:0]];
            end
        end
    end

    // Job counters, packing and the sticky framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q      <= '0;
            beat_idx    <= '0;
            beat_cnt    <= '0;
            rows_packed <= '0;
            pop_cnt     <= '0;
            gap_cnt     <= '0;
            err_len     <= 1'b0;
        end else if (job_go) begin
            beat_idx    <= '0;
            beat_cnt    <= '0;
            rows_packed <= '0;
            pop_cnt     <= '0;
            gap_cnt     <= '0;
            err_len     <= 1'b0;
        end else begin
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (pop) begin
                pop_cnt <= (pop_cnt == LAST_ROW) ? '0 : pop_cnt + 1'b1;
            end
            if (accept) begin
                pack_q   <= row_in;
                beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
                if (in_tlast != tlast_exp) begin
                    err_len <= 1'b1;
                end
            end
            if (push) begin
                rows_packed <= rows_packed + 1'b1;
            end
        end
    end

    // Packed-row FIFO storage and pointers (extra MSB distinguishes full from empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= row_in;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
